// File: rtl/ssit.sv
// Store Set Identifier Table: PC-indexed SSID lookup with touch reporting to sst,
// violation-driven store-set merging, and a grouped full-table clear walker.
module ssit #(
    parameter int SSIT_ENTRIES    = 1024,
    parameter int SSID_WIDTH      = 6,
    parameter int CLEAR_PER_CYCLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_PC,
    output logic                  lookup_resp_valid,
    output logic                  lookup_resp_hit,
    output logic [SSID_WIDTH-1:0] lookup_resp_SSID,
    input  logic                  update_valid,
    output logic                  update_ready,
    input  logic [31:0]           update_store_PC,
    input  logic [31:0]           update_load_PC,
    output logic                  new_SSID_valid,
    input  logic [SSID_WIDTH-1:0] new_SSID,
    output logic                  touch_SSID_valid,
    output logic [SSID_WIDTH-1:0] touch_SSID,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  dbg_state   // 0 = IDLE, 1 = CLEARING
);

    localparam int INDEX_BITS = $clog2(SSIT_ENTRIES);

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef enum logic {IDLE = 1'b0, CLEARING = 1'b1} state_t;

    localparam idx_t LAST_PTR  = idx_t'(SSIT_ENTRIES - CLEAR_PER_CYCLE);
    localparam idx_t PTR_STEP  = idx_t'(CLEAR_PER_CYCLE);

    state_t state_q, state_d;
    idx_t   ptr_q, ptr_d;
    logic   clear_en;

    logic [SSIT_ENTRIES-1:0] valid_q;
    logic [SSID_WIDTH-1:0]   ssid_mem [SSIT_ENTRIES];

    idx_t look_idx, s_idx, l_idx;
    logic look_hit;
    logic upd_acc, vs, vl, wr_s, wr_l, alloc;
    logic [SSID_WIDTH-1:0] ssid_s, ssid_l, wr_data;

    // Only the XOR-folded PC bits select an entry; the rest are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_PC[31:2*INDEX_BITS+2], lookup_PC[1:0],
                              update_store_PC[31:2*INDEX_BITS+2], update_store_PC[1:0],
                              update_load_PC[31:2*INDEX_BITS+2], update_load_PC[1:0]};

    assign look_idx = lookup_PC[INDEX_BITS+1:2] ^ lookup_PC[2*INDEX_BITS+1:INDEX_BITS+2];
    assign s_idx    = update_store_PC[INDEX_BITS+1:2] ^ update_store_PC[2*INDEX_BITS+1:INDEX_BITS+2];
    assign l_idx    = update_load_PC[INDEX_BITS+1:2] ^ update_load_PC[2*INDEX_BITS+1:INDEX_BITS+2];

    // Handshake: an update transfers in any cycle with update_valid && update_ready;
    // ready is high exactly while IDLE and does not depend on update_valid.
    assign update_ready = (state_q == IDLE);
    assign clear_busy   = (state_q == CLEARING);
    assign dbg_state    = state_q;
    assign upd_acc      = update_valid & update_ready;

    assign look_hit = lookup_valid & valid_q[look_idx] & (state_q == IDLE);
    assign vs       = valid_q[s_idx];
    assign vl       = valid_q[l_idx];
    assign ssid_s   = ssid_mem[s_idx];
    assign ssid_l   = ssid_mem[l_idx];

    // Merge rules: both PCs end up in one store set; a fresh SSID only when neither has one.
    always_comb begin
        wr_s    = 1'b0;
        wr_l    = 1'b0;
        alloc   = 1'b0;
        wr_data = ssid_s;
        if (upd_acc) begin
            if (s_idx == l_idx) begin
                if (!vs) begin
                    alloc   = 1'b1;
                    wr_s    = 1'b1;
                    wr_data = new_SSID;
                end
            end else begin
                case ({vs, vl})
                    2'b00: begin
                        alloc   = 1'b1;
                        wr_s    = 1'b1;
                        wr_l    = 1'b1;
                        wr_data = new_SSID;
                    end
                    2'b10: begin
                        wr_l    = 1'b1;
                        wr_data = ssid_s;
                    end
                    2'b01: begin
                        wr_s    = 1'b1;
                        wr_data = ssid_l;
                    end
                    default: begin
                        if (ssid_s != ssid_l) begin
                            wr_s    = 1'b1;
                            wr_l    = 1'b1;
                            wr_data = (ssid_s < ssid_l) ? ssid_s : ssid_l;
                        end
                    end
                endcase
            end
        end
    end

    assign new_SSID_valid = alloc;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clear_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) state_d = CLEARING;
            end
            CLEARING: begin
                clear_en = 1'b1;
                ptr_d    = ptr_q + PTR_STEP;   // wraps to 0 after the last group
                if (ptr_q == LAST_PTR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Updates only happen in IDLE and clearing only in CLEARING, so they never collide.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else begin
            if (clear_en) begin
                for (int k = 0; k < CLEAR_PER_CYCLE; k++) begin
                    valid_q[ptr_q + idx_t'(k)] <= 1'b0;
                end
            end
            if (wr_s) valid_q[s_idx] <= 1'b1;
            if (wr_l) valid_q[l_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_s) ssid_mem[s_idx] <= wr_data;
        if (wr_l) ssid_mem[l_idx] <= wr_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lookup_resp_valid <= 1'b0;
            lookup_resp_hit   <= 1'b0;
            lookup_resp_SSID  <= '0;
            touch_SSID_valid  <= 1'b0;
            touch_SSID        <= '0;
        end else begin
            lookup_resp_valid <= lookup_valid;
            lookup_resp_hit   <= look_hit;
            lookup_resp_SSID  <= look_hit ? ssid_mem[look_idx] : '0;
            touch_SSID_valid  <= look_hit;
            touch_SSID        <= look_hit ? ssid_mem[look_idx] : '0;
        end
    end

endmodule

// File: tb/tb_ssit.sv
// Self-checking bench for ssit: directed scenarios plus random traffic against a
// store-set model held as an index-keyed associative array.
module tb_ssit;

    localparam int CLEAR_CYCLES = 128;

    logic        CLK;
    logic        RST;
    logic        lookup_valid;
    logic [31:0] lookup_PC;
    logic        lookup_resp_valid;
    logic        lookup_resp_hit;
    logic [5:0]  lookup_resp_SSID;
    logic        update_valid;
    logic        update_ready;
    logic [31:0] update_store_PC;
    logic [31:0] update_load_PC;
    logic        new_SSID_valid;
    logic [5:0]  new_SSID;
    logic        touch_SSID_valid;
    logic [5:0]  touch_SSID;
    logic        clear_req;
    logic        clear_busy;
    logic        dbg_state;

    ssit dut (
        .CLK(CLK), .RST(RST),
        .lookup_valid(lookup_valid), .lookup_PC(lookup_PC),
        .lookup_resp_valid(lookup_resp_valid), .lookup_resp_hit(lookup_resp_hit),
        .lookup_resp_SSID(lookup_resp_SSID),
        .update_valid(update_valid), .update_ready(update_ready),
        .update_store_PC(update_store_PC), .update_load_PC(update_load_PC),
        .new_SSID_valid(new_SSID_valid), .new_SSID(new_SSID),
        .touch_SSID_valid(touch_SSID_valid), .touch_SSID(touch_SSID),
        .clear_req(clear_req), .clear_busy(clear_busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec;
    int n_err;
    logic [5:0] model [int];   // index -> SSID; presence means valid
    int busy_cnt;              // remaining clear cycles
    logic [31:0] pool [16];

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[11:2] ^ pc[21:12]);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic drive_cycle(input logic lv, input logic [31:0] lpc, input logic uv,
                               input logic [31:0] spc, input logic [31:0] ldpc,
                               input logic [5:0] nid, input logic clr);
        logic idle, exp_hit, exp_alloc, ws, wl;
        logic [5:0] exp_id, tgt;
        int li, s, l;
        lookup_valid    = lv;
        lookup_PC       = lpc;
        update_valid    = uv;
        update_store_PC = spc;
        update_load_PC  = ldpc;
        new_SSID        = nid;
        clear_req       = clr;

        idle    = (busy_cnt == 0);
        li      = idx_of(lpc);
        exp_hit = lv && idle && model.exists(li);
        exp_id  = exp_hit ? model[li] : 6'd0;
        exp_alloc = 1'b0; ws = 1'b0; wl = 1'b0; tgt = 6'd0;
        s = idx_of(spc);
        l = idx_of(ldpc);
        if (uv && idle) begin
            if (!model.exists(s) && !model.exists(l)) begin
                exp_alloc = 1'b1; tgt = nid; ws = 1'b1; wl = 1'b1;
            end else if (!model.exists(l)) begin
                tgt = model[s]; wl = 1'b1;
            end else if (!model.exists(s)) begin
                tgt = model[l]; ws = 1'b1;
            end else begin
                tgt = (model[s] < model[l]) ? model[s] : model[l];
                ws = 1'b1; wl = 1'b1;
            end
        end

        #1;
        check_eq("update_ready", update_ready, idle);
        check_eq("new_SSID_valid", new_SSID_valid, exp_alloc);
        check_eq("clear_busy", clear_busy, !idle);
        check_eq("dbg_state", dbg_state, !idle);

        @(posedge CLK);
        #1;
        check_eq("resp_valid", lookup_resp_valid, lv);
        if (lv) begin
            check_eq("resp_hit", lookup_resp_hit, exp_hit);
            check_eq("resp_SSID", lookup_resp_SSID, exp_id);
        end
        check_eq("touch_valid", touch_SSID_valid, exp_hit);
        if (exp_hit) check_eq("touch_SSID", touch_SSID, exp_id);

        if (ws) model[s] = tgt;
        if (wl) model[l] = tgt;
        if (busy_cnt > 0) busy_cnt--;
        else if (clr) begin
            model.delete();
            busy_cnt = CLEAR_CYCLES;
        end
    endtask

    task automatic look(input logic [31:0] pc);
        drive_cycle(1'b1, pc, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] spc, input logic [31:0] ldpc, input logic [5:0] nid);
        drive_cycle(1'b0, 32'h0, 1'b1, spc, ldpc, nid, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_resp_valid"}, lookup_resp_valid, 1'b0);
        check_eq({tag, "_resp_hit"}, lookup_resp_hit, 1'b0);
        check_eq({tag, "_resp_SSID"}, lookup_resp_SSID, 6'd0);
        check_eq({tag, "_touch_valid"}, touch_SSID_valid, 1'b0);
        check_eq({tag, "_touch_SSID"}, touch_SSID, 6'd0);
        check_eq({tag, "_clear_busy"}, clear_busy, 1'b0);
        check_eq({tag, "_state"}, dbg_state, 1'b0);
        check_eq({tag, "_ready"}, update_ready, 1'b1);
        check_eq({tag, "_alloc"}, new_SSID_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] r;
        n_vec = 0; n_err = 0; busy_cnt = 0;
        RST = 1'b1;
        lookup_valid = 1'b0; lookup_PC = '0; update_valid = 1'b0;
        update_store_PC = '0; update_load_PC = '0; new_SSID = '0; clear_req = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;

        // empty table misses
        look(32'h1000);

        // neither valid: allocate 5 into both
        upd(32'h2000, 32'h3000, 6'd5);
        look(32'h2000);
        look(32'h3000);

        // store set 3 vs load set 9, then 9 vs 3: smaller wins
        upd(32'h4000, 32'h5000, 6'd3);
        upd(32'h6000, 32'h7000, 6'd9);
        upd(32'h4000, 32'h6000, 6'd40);
        look(32'h4000);
        look(32'h6000);
        look(32'h7000);
        upd(32'h7000, 32'h5000, 6'd41);
        look(32'h7000);
        look(32'h5000);

        // only store valid / only load valid
        upd(32'h2000, 32'hB000, 6'd42);
        look(32'hB000);
        upd(32'hC000, 32'h3000, 6'd43);
        look(32'hC000);

        // store and load alias to one index (0x8000 and 0x20 both map to 8)
        upd(32'h8000, 32'h0000_0020, 6'd7);
        look(32'h8000);
        look(32'h0000_0020);
        upd(32'h8000, 32'h0000_0020, 6'd11);

        // same-cycle lookup and allocating update on one PC
        drive_cycle(1'b1, 32'h9000, 1'b1, 32'h9000, 32'hA000, 6'd12, 1'b0);
        look(32'h9000);

        // clear with a same-cycle accepted update, then blocked updates and missing lookups
        drive_cycle(1'b1, 32'h2000, 1'b1, 32'hD000, 32'hE000, 6'd20, 1'b1);
        for (int i = 0; i < CLEAR_CYCLES; i++) begin
            drive_cycle(1'b1, (i % 2) ? 32'h2000 : 32'hD000, 1'b1, 32'h2000, 32'h3000,
                        6'd21, (i == 5));
        end
        look(32'h2000);
        look(32'h4000);
        look(32'h8000);
        look(32'hD000);
        upd(32'h2000, 32'h3000, 6'd22);
        look(32'h3000);

        // reset asserted in the middle of a clear
        drive_cycle(1'b1, 32'h2000, 1'b0, 32'h0, 32'h0, 6'd0, 1'b1);
        for (int i = 0; i < 10; i++) look(32'h3000);
        lookup_valid = 1'b1;
        update_valid = 1'b0;
        clear_req    = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("midclear_rst");
        model.delete();
        busy_cnt = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        look(32'h3000);

        // random traffic over a small, heavily aliasing PC pool
        for (int i = 0; i < 16; i++) begin
            r = $urandom();
            pool[i] = {r[31:22], 10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)), 2'b00};
        end
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)],
                        ($urandom_range(0, 2) == 0), pool[$urandom_range(0, 15)],
                        pool[$urandom_range(0, 15)], 6'($urandom_range(0, 63)),
                        ($urandom_range(0, 249) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
